block_miner: RTL and testbench
==============================

# block_miner

Proof-of-work search engine that sits directly downstream of the memory controller. It captures the previous block hash and the 48-bit block data. On `enable_mining` it walks nonces upward from 0, computing an 8-bit chained hash over {data, nonce} seeded with the previous hash. It stops at the first hash whose top `DIFFICULTY` bits are zero, then holds `mining_hash`/`done_mining` for the controller to write back.

## Interface
- `DIFFICULTY`, default 3: number of leading hash bits that must be zero; legal range 1..8.
- `NONCE_W`, default 8: nonce width, legal range 1..8; the nonce is zero-extended to 8 bits for hashing.
- `clock`  in  1: system clock; all state changes on the rising edge.
- `resetn`  in  1: reset, synchronous, active-low.
- `enable_mining`  in  1: level request from the memory controller; must stay high until `done_mining` is seen.
- `load_previous_hash`  in  1: capture strobe for `prev_hash_in`.
- `prev_hash_in`  in  8: previous block hash, the low byte of the memory read data.
- `block_data`  in  48: block contents from the data registers.
- `mining_hash`  out  8: final hash of the last search; held until the next search completes.
- `nonce_out`  out  NONCE_W: nonce that produced `mining_hash`.
- `done_mining`  out  1: search finished; level signal.
- `mine_fail`  out  1: all nonces tried with no hit; valid while `done_mining` is high.
- `busy`  out  1: high in HASH and CHECK.

## Operation
- Round function `r(h,b) = ({h[4:0],h[7:5]} ^ b) + 8'h3B`, computed mod 256 (carry dropped).
- Per-nonce hash, 7 rounds:
  - start from `h = prev`;
  - rounds 0..5 apply data bytes in order `block_data[47:40]` down to `[7:0]`;
  - round 6 applies the zero-extended nonce.
- Hit condition: `h[7:8-DIFFICULTY] == 0`.
- `prev` register:
  - loads `prev_hash_in` on any edge where `load_previous_hash`=1 and state is IDLE or DONE;
  - ignored in HASH and CHECK.
  - If `load_previous_hash` and `enable_mining` are both sampled in IDLE on the same edge, the new `prev_hash_in` seeds the search (bypass).
- States:
  - **IDLE**: on `enable_mining`=1, snapshot `block_data`, set `nonce`=0, `h`=prev, `round`=0, and go to HASH.
  - **HASH**: one round per cycle. After round 6, go to CHECK.
  - **CHECK**, in priority order:
    - hit: latch `mining_hash`=h and `nonce_out`=nonce, set `mine_fail`=0, go to DONE;
    - else if `nonce` = 2^NONCE_W−1: latch the same registers with `mine_fail`=1, go to DONE;
    - else: `nonce`+1, `h`=prev, `round`=0, go to HASH.
  - **DONE**: `done_mining`=1. Stay while `enable_mining`=1. When `enable_mining`=0, go to IDLE on the next edge; `done_mining` falls, `mining_hash`/`nonce_out` are retained.
- Abort: `enable_mining`=0 while in HASH or CHECK returns to IDLE on the next edge.
  - Result registers and `done_mining` are unchanged (stay 0).
  - A later `enable_mining` restarts at nonce 0.
- Reset, any state: state=IDLE. `mining_hash`, `nonce_out`, `done_mining`, `mine_fail`, `busy` and `prev` all reset to 0. Reset has priority over every other input.

## Timing
- Let edge 0 be the edge that samples `enable_mining`=1 in IDLE. For a hit at nonce n, `done_mining` rises after edge 8+8n (7 HASH cycles + 1 CHECK cycle per nonce).
- Worst case: `done_mining` rises after edge 8·2^NONCE_W.
- `busy` is high from after edge 0 until `done_mining` rises; it never overlaps `done_mining`.
- `mining_hash` is stable from the `done_mining` rise through DONE and all following IDLE cycles. The controller writes it back after `enable_mining` drops.
- `block_data` may change after edge 0 without effect on the running search.

## Structure
- Shared package holds:
  - constants `HASH_ADD = 8'h3B`, `HASH_ROT = 3`, `DATA_BYTES = 6`;
  - state encoding IDLE/HASH/CHECK/DONE.
- One combinational sub-module, `hash_round`: 8-bit `h` and `b` in, next 8-bit `h` out. It is reused by the bench's reference model.

## Test plan
- `block_data`=0, prev=0x00, DIFFICULTY=3, NONCE_W=8:
  - `done_mining` rises after edge 520;
  - `mining_hash`=0x15, `nonce_out`=0x40, `mine_fail`=0;
  - `busy` is high for 520 cycles.
- Same data, DIFFICULTY=8: `mining_hash`=0x00, `nonce_out`=0x5F, `done_mining` rises after edge 768.
- Same data, NONCE_W=4, DIFFICULTY=3: `done_mining` rises after edge 128 with `mine_fail`=1, `mining_hash`=0xD0, `nonce_out`=0xF.
- Abort and restart:
  - drop `enable_mining` at cycle 100 of the first test → IDLE next edge, `done_mining` stays 0, `mining_hash` keeps its prior value;
  - re-enable → same 0x15/0x40 result, 520 cycles after the new edge 0.
- Handshake and capture:
  - hold `enable_mining` 5 extra cycles in DONE → `done_mining` stays 1;
  - drop `enable_mining` → `done_mining` is 0 after one edge, `mining_hash` is retained;
  - a `load_previous_hash` strobe during HASH is ignored;
  - a strobe in the same cycle as `enable_mining` in IDLE seeds the search.
- Reset mid-search: assert `resetn`=0 for one edge during HASH → all outputs 0 and state IDLE on that edge.

Source files
------------

// File: rtl/block_miner_pkg.sv
// block_miner_pkg: shared constants and state encoding for the proof-of-work miner.
//   HASH_ADD / HASH_ROT : round-function constants (rotate-left then xor then add)
//   DATA_BYTES          : number of block-data bytes folded in before the nonce
//   state_t             : miner FSM states
package block_miner_pkg;

  localparam logic [7:0]  HASH_ADD   = 8'h3B;
  localparam int unsigned HASH_ROT   = 3;
  localparam int unsigned DATA_BYTES = 6;

  localparam int unsigned HASH_W  = 8;
  localparam int unsigned DATA_W  = DATA_BYTES * 8;
  localparam int unsigned ROUND_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HASH  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/block_miner_if.sv
// block_miner_if: request/result bundle between the memory controller and the miner.
//   master : controller side (drives enable/load/prev/data, reads results)
//   slave  : miner side
interface block_miner_if #(
  parameter int unsigned NONCE_W = 8
);
  import block_miner_pkg::*;

  logic                enable_mining;
  logic                load_previous_hash;
  logic [HASH_W-1:0]   prev_hash_in;
  logic [DATA_W-1:0]   block_data;
  logic [HASH_W-1:0]   mining_hash;
  logic [NONCE_W-1:0]  nonce_out;
  logic                done_mining;
  logic                mine_fail;
  logic                busy;

  modport master (
    output enable_mining, load_previous_hash, prev_hash_in, block_data,
    input  mining_hash, nonce_out, done_mining, mine_fail, busy
  );

  modport slave (
    input  enable_mining, load_previous_hash, prev_hash_in, block_data,
    output mining_hash, nonce_out, done_mining, mine_fail, busy
  );

endinterface

// File: rtl/block_miner_hash_round.sv
// hash_round: one combinational round of the chained hash.
//   h        : current 8-bit hash state
//   b        : byte folded in this round
//   h_next_c : ({h[4:0],h[7:5]} ^ b) + HASH_ADD, carry dropped
module hash_round
  import block_miner_pkg::*;
(
  input  logic [HASH_W-1:0] h,
  input  logic [HASH_W-1:0] b,
  output logic [HASH_W-1:0] h_next_c
);

  logic [HASH_W-1:0] rot_c;

  // Rotate left by HASH_ROT.
  assign rot_c    = {h[HASH_W-HASH_ROT-1:0], h[HASH_W-1:HASH_W-HASH_ROT]};
  assign h_next_c = (rot_c ^ b) + HASH_ADD;

endmodule

// File: rtl/block_miner.sv
// block_miner: nonce search engine. Walks nonces upward from 0, hashing
// {block_data, nonce} seeded with the previous hash, until the top DIFFICULTY
// bits of the hash are zero or the nonce space is exhausted.
//   clock, resetn : clock and synchronous active-low reset
//   bus (slave)   : enable/load/prev/data in; mining_hash, nonce_out,
//                   done_mining, mine_fail, busy out (all registered)
module block_miner
  import block_miner_pkg::*;
#(
  parameter int unsigned DIFFICULTY = 3,
  parameter int unsigned NONCE_W    = 8
) (
  input  logic        clock,
  input  logic        resetn,
  block_miner_if.slave bus
);

  localparam logic [HASH_W-1:0]  HIT_MASK   = HASH_W'(8'hFF << (HASH_W - DIFFICULTY));
  localparam logic [NONCE_W-1:0] NONCE_MAX  = '1;
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(DATA_BYTES);

  state_t               state_q, state_d;
  logic [HASH_W-1:0]    prev_q, prev_d;
  logic [HASH_W-1:0]    h_q, h_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic [NONCE_W-1:0]   nonce_q, nonce_d;
  logic [HASH_W-1:0]    hash_q, hash_d;
  logic [NONCE_W-1:0]   nonce_out_q, nonce_out_d;
  logic                 fail_q, fail_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic [HASH_W-1:0]    rnd_b_c;
  logic [HASH_W-1:0]    rnd_h_c;
  logic                 hit_c;
  logic                 last_nonce_c;

  // Byte for the current round: data bytes MSB first, then the nonce.
  always_comb begin
    rnd_b_c = HASH_W'(nonce_q);
    case (round_q)
      3'd0:    rnd_b_c = data_q[47:40];
      3'd1:    rnd_b_c = data_q[39:32];
      3'd2:    rnd_b_c = data_q[31:24];
      3'd3:    rnd_b_c = data_q[23:16];
      3'd4:    rnd_b_c = data_q[15:8];
      3'd5:    rnd_b_c = data_q[7:0];
      default: rnd_b_c = HASH_W'(nonce_q);
    endcase
  end

  hash_round u_round (
    .h        (h_q),
    .b        (rnd_b_c),
    .h_next_c (rnd_h_c)
  );

  assign hit_c        = (h_q & HIT_MASK) == '0;
  assign last_nonce_c = (nonce_q == NONCE_MAX);

  // Next-state and next-register logic.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    h_d         = h_q;
    data_d      = data_q;
    round_d     = round_q;
    nonce_d     = nonce_q;
    hash_d      = hash_q;
    nonce_out_d = nonce_out_q;
    fail_d      = fail_q;

    // prev is only writable while no search is in flight.
    if (bus.load_previous_hash && (state_q == IDLE || state_q == DONE)) begin
      prev_d = bus.prev_hash_in;
    end

    case (state_q)
      IDLE: begin
        if (bus.enable_mining) begin
          data_d  = bus.block_data;
          nonce_d = '0;
          // Same-edge load seeds the search directly.
          h_d     = bus.load_previous_hash ? bus.prev_hash_in : prev_q;
          round_d = '0;
          state_d = HASH;
        end
      end
      HASH: begin
        if (!bus.enable_mining) begin
          state_d = IDLE;
        end else begin
          h_d     = rnd_h_c;
          round_d = round_q + ROUND_W'(1);
          if (round_q == LAST_ROUND) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (!bus.enable_mining) begin
          state_d = IDLE;
        end else if (hit_c || last_nonce_c) begin
          hash_d      = h_q;
          nonce_out_d = nonce_q;
          fail_d      = !hit_c;
          state_d     = DONE;
        end else begin
          nonce_d = nonce_q + NONCE_W'(1);
          h_d     = prev_q;
          round_d = '0;
          state_d = HASH;
        end
      end
      DONE: begin
        if (!bus.enable_mining) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d == HASH) || (state_d == CHECK);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      h_q         <= '0;
      data_q      <= '0;
      round_q     <= '0;
      nonce_q     <= '0;
      hash_q      <= '0;
      nonce_out_q <= '0;
      fail_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      h_q         <= h_d;
      data_q      <= data_d;
      round_q     <= round_d;
      nonce_q     <= nonce_d;
      hash_q      <= hash_d;
      nonce_out_q <= nonce_out_d;
      fail_q      <= fail_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mining_hash = hash_q;
  assign bus.nonce_out   = nonce_out_q;
  assign bus.done_mining = done_q;
  assign bus.mine_fail   = fail_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_block_miner.sv
// tb_block_miner: runs three miner configurations side by side
// (D3/N8, D8/N8, D3/N4) from shared controller stimulus and checks them
// against a plain-arithmetic search model.
module tb_block_miner;
  import block_miner_pkg::*;

  localparam int DIFF [3] = '{3, 8, 3};
  localparam int NW   [3] = '{8, 8, 4};

  logic        clock = 1'b0;
  logic        resetn;
  logic        en;
  logic        load;
  logic [7:0]  prev_in;
  logic [47:0] data;

  always #5 clock = ~clock;

  block_miner_if #(.NONCE_W(8)) if_a ();
  block_miner_if #(.NONCE_W(8)) if_b ();
  block_miner_if #(.NONCE_W(4)) if_c ();

  assign if_a.enable_mining = en;  assign if_a.load_previous_hash = load;
  assign if_a.prev_hash_in  = prev_in; assign if_a.block_data = data;
  assign if_b.enable_mining = en;  assign if_b.load_previous_hash = load;
  assign if_b.prev_hash_in  = prev_in; assign if_b.block_data = data;
  assign if_c.enable_mining = en;  assign if_c.load_previous_hash = load;
  assign if_c.prev_hash_in  = prev_in; assign if_c.block_data = data;

  block_miner #(.DIFFICULTY(3), .NONCE_W(8)) dut_a (.clock(clock), .resetn(resetn), .bus(if_a.slave));
  block_miner #(.DIFFICULTY(8), .NONCE_W(8)) dut_b (.clock(clock), .resetn(resetn), .bus(if_b.slave));
  block_miner #(.DIFFICULTY(3), .NONCE_W(4)) dut_c (.clock(clock), .resetn(resetn), .bus(if_c.slave));

  logic [7:0] hr_h, hr_b, hr_o;
  hash_round u_hr (.h(hr_h), .b(hr_b), .h_next_c(hr_o));

  logic [7:0] o_hash  [3];
  logic [7:0] o_nonce [3];
  logic       o_done  [3];
  logic       o_fail  [3];
  logic       o_busy  [3];

  assign o_hash[0] = if_a.mining_hash; assign o_nonce[0] = 8'(if_a.nonce_out);
  assign o_hash[1] = if_b.mining_hash; assign o_nonce[1] = 8'(if_b.nonce_out);
  assign o_hash[2] = if_c.mining_hash; assign o_nonce[2] = 8'(if_c.nonce_out);
  assign o_done[0] = if_a.done_mining; assign o_fail[0] = if_a.mine_fail; assign o_busy[0] = if_a.busy;
  assign o_done[1] = if_b.done_mining; assign o_fail[1] = if_b.mine_fail; assign o_busy[1] = if_b.busy;
  assign o_done[2] = if_c.done_mining; assign o_fail[2] = if_c.mine_fail; assign o_busy[2] = if_c.busy;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] mprev;
  int         res_edge [3];
  int         res_busy [3];
  logic [7:0] exp_hash [3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Rotate-left-3 done with multiply/divide, then xor and add mod 256.
  function automatic logic [7:0] ref_round(input logic [7:0] h, input logic [7:0] b);
    int hi, t;
    hi = int'(h);
    t  = (((hi * 8) % 256) + (hi / 32)) ^ int'(b);
    return 8'((t + 59) % 256);
  endfunction

  function automatic void ref_search(input logic [7:0] p, input logic [47:0] d,
                                     input int diff, input int nw,
                                     output logic [7:0] mh, output int nn,
                                     output bit fl, output int edges);
    logic [7:0] h;
    int limit, lim_hash;
    limit    = 1 << nw;
    lim_hash = 1 << (8 - diff);
    fl = 1'b1; nn = limit - 1; mh = 8'h00; edges = 8 * limit;
    for (int n = 0; n < limit; n++) begin
      h = p;
      for (int i = 0; i < 6; i++) h = ref_round(h, d[47 - 8 * i -: 8]);
      h = ref_round(h, 8'(n));
      if (int'(h) < lim_hash) begin
        mh = h; nn = n; fl = 1'b0; edges = 8 + 8 * n;
        return;
      end
      if (n == limit - 1) mh = h;
    end
  endfunction

  task automatic load_prev(input logic [7:0] v);
    load = 1'b1; prev_in = v;
    tick();
    load = 1'b0;
    mprev = v;
  endtask

  // Run one search on all three miners; leaves enable_mining high.
  task automatic do_search(input logic [47:0] dat, input bit bypass, input logic [7:0] bval,
                           input bit midload, input string tag);
    logic [7:0] seed, eh;
    int         cyc, en_n, ee;
    bit         efl, all_done;
    data = dat; en = 1'b1;
    if (bypass) begin load = 1'b1; prev_in = bval; mprev = bval; end
    seed = mprev;
    for (int k = 0; k < 3; k++) begin res_edge[k] = -1; res_busy[k] = 0; end
    cyc = 0;
    tick();
    load = 1'b0;
    data = {$urandom, 16'($urandom)};
    while (cyc < 2100) begin
      all_done = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (o_busy[k] === 1'b1) res_busy[k]++;
        if (o_done[k] === 1'b1 && res_edge[k] < 0) res_edge[k] = cyc;
        if (o_done[k] !== 1'b1) all_done = 1'b0;
        check($sformatf("%s_overlap%0d", tag, k), 64'(o_busy[k] & o_done[k]), 64'd0);
      end
      if (all_done) break;
      if (midload && cyc == 3) begin load = 1'b1; prev_in = 8'($urandom); end
      else load = 1'b0;
      tick();
      cyc++;
    end
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ref_search(seed, dat, DIFF[k], NW[k], eh, en_n, efl, ee);
      exp_hash[k] = eh;
      check($sformatf("%s_edge%0d", tag, k),  64'(res_edge[k]), 64'(ee));
      check($sformatf("%s_busy%0d", tag, k),  64'(res_busy[k]), 64'(ee));
      check($sformatf("%s_hash%0d", tag, k),  64'(o_hash[k]),   64'(eh));
      check($sformatf("%s_nonce%0d", tag, k), 64'(o_nonce[k]),  64'(en_n));
      check($sformatf("%s_fail%0d", tag, k),  64'(o_fail[k]),   64'(efl));
    end
  endtask

  task automatic drop(input string tag);
    en = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_done%0d", tag, k), 64'(o_done[k]), 64'd0);
      check($sformatf("%s_busy%0d", tag, k), 64'(o_busy[k]), 64'd0);
      check($sformatf("%s_keep%0d", tag, k), 64'(o_hash[k]), 64'(exp_hash[k]));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_hash%0d", tag, k),  64'(o_hash[k]),  64'd0);
      check($sformatf("%s_nonce%0d", tag, k), 64'(o_nonce[k]), 64'd0);
      check($sformatf("%s_done%0d", tag, k),  64'(o_done[k]),  64'd0);
      check($sformatf("%s_fail%0d", tag, k),  64'(o_fail[k]),  64'd0);
      check($sformatf("%s_busy%0d", tag, k),  64'(o_busy[k]),  64'd0);
    end
  endtask

  initial begin
    resetn = 1'b0; en = 1'b0; load = 1'b0; prev_in = 8'h00; data = 48'h0;
    mprev = 8'h00; hr_h = 8'h00; hr_b = 8'h00;
    for (int k = 0; k < 3; k++) exp_hash[k] = 8'h00;
    tick(); tick();
    check_zero("reset");
    resetn = 1'b1;
    tick();

    // Round function against the arithmetic reference.
    for (int i = 0; i < 6; i++) begin
      hr_h = 8'($urandom); hr_b = 8'($urandom);
      #1;
      check($sformatf("round%0d", i), 64'(hr_o), 64'(ref_round(hr_h, hr_b)));
    end

    // Zero data, zero prev: known results.
    do_search(48'h0, 1'b0, 8'h00, 1'b0, "zero");
    check("zero_a_hash", 64'(o_hash[0]), 64'h15);
    check("zero_a_nonce", 64'(o_nonce[0]), 64'h40);
    check("zero_a_edge", 64'(res_edge[0]), 64'd520);
    check("zero_a_busy", 64'(res_busy[0]), 64'd520);
    check("zero_b_hash", 64'(o_hash[1]), 64'h00);
    check("zero_b_nonce", 64'(o_nonce[1]), 64'h5F);
    check("zero_b_edge", 64'(res_edge[1]), 64'd768);
    check("zero_c_hash", 64'(o_hash[2]), 64'hD0);
    check("zero_c_nonce", 64'(o_nonce[2]), 64'h0F);
    check("zero_c_fail", 64'(o_fail[2]), 64'd1);
    check("zero_c_edge", 64'(res_edge[2]), 64'd128);

    // Hold enable in DONE.
    for (int i = 0; i < 5; i++) begin
      tick();
      for (int k = 0; k < 3; k++) check($sformatf("hold%0d_%0d", i, k), 64'(o_done[k]), 64'd1);
    end
    drop("drop0");

    // Abort mid-search, then restart.
    en = 1'b1; data = 48'h0;
    tick();
    repeat (99) tick();
    en = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("abort_busy%0d", k), 64'(o_busy[k]), 64'd0);
      check($sformatf("abort_done%0d", k), 64'(o_done[k]), 64'd0);
      check($sformatf("abort_keep%0d", k), 64'(o_hash[k]), 64'(exp_hash[k]));
    end
    tick();
    do_search(48'h0, 1'b0, 8'h00, 1'b0, "restart");
    check("restart_hash", 64'(o_hash[0]), 64'h15);
    check("restart_nonce", 64'(o_nonce[0]), 64'h40);
    check("restart_edge", 64'(res_edge[0]), 64'd520);
    drop("drop1");

    // Load strobe during HASH is ignored; same-edge strobe seeds the search.
    do_search({$urandom, 16'($urandom)}, 1'b0, 8'h00, 1'b1, "midload");
    drop("drop2");
    do_search({$urandom, 16'($urandom)}, 1'b1, 8'($urandom), 1'b0, "bypass");
    drop("drop3");

    // Randomized searches.
    for (int r = 0; r < 3; r++) begin
      load_prev(8'($urandom));
      do_search({$urandom, 16'($urandom)}, 1'($urandom), 8'($urandom), 1'($urandom),
                $sformatf("rand%0d", r));
      drop($sformatf("rdrop%0d", r));
    end

    // Reset during HASH.
    en = 1'b1; data = {$urandom, 16'($urandom)};
    tick();
    repeat (3) tick();
    resetn = 1'b0;
    tick();
    check_zero("midreset");
    resetn = 1'b1; en = 1'b0; mprev = 8'h00;
    for (int k = 0; k < 3; k++) exp_hash[k] = 8'h00;
    tick();
    do_search({$urandom, 16'($urandom)}, 1'b0, 8'h00, 1'b0, "postreset");
    drop("drop4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
